// File: rtl/peripheral_dbg_soc_ctm_trace_mux_if.sv
// Merged trace-event stream from the CTM trace mux to the packetiser.
// Handshake: an event transfers on a rising clk edge where ev_valid && ev_ready; while
// ev_valid is high and ev_ready is low the producer holds every ev_* field stable.
interface peripheral_dbg_soc_ctm_trace_mux_if #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TIME_WIDTH = 32
);
  localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                  ev_valid;
  logic                  ev_ready;
  logic [CID_W-1:0]      ev_core_id;
  logic [ADDR_WIDTH-1:0] ev_pc;
  logic [ADDR_WIDTH-1:0] ev_npc;
  logic [1:0]            ev_kind;
  logic [TIME_WIDTH-1:0] ev_time;
  logic [7:0]            ev_lost;

  modport master (
    output ev_valid, ev_core_id, ev_pc, ev_npc, ev_kind, ev_time, ev_lost,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_core_id, ev_pc, ev_npc, ev_kind, ev_time, ev_lost,
    output ev_ready
  );
endinterface

// File: rtl/peripheral_dbg_soc_ctm_trace_mux.sv
// Multi-core trace mux: per-core filter, timestamp and FIFO, lost-event counting,
// and a round-robin merge into one registered valid/ready event stream.
module peripheral_dbg_soc_ctm_trace_mux #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIME_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [1:0]                      filter_mode,
  input  logic [NUM_CORES-1:0]            trace_valid,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] trace_pc,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] trace_npc,
  input  logic [NUM_CORES-1:0]            trace_jal,
  input  logic [NUM_CORES-1:0]            trace_jalr,
  peripheral_dbg_soc_ctm_trace_mux_if.master ev
);
  localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] npc;
    logic [1:0]            kind;
    logic [TIME_WIDTH-1:0] ts;
    logic [7:0]            lost;
  } entry_t;

  logic [TIME_WIDTH-1:0] ts_cnt;
  logic [CID_W-1:0]      rr_ptr;
  logic [CID_W-1:0]      gnt_id;
  logic [CID_W:0]        scan_idx;
  logic                  gnt_found;
  logic                  out_load;
  logic [NUM_CORES-1:0]  qual;
  logic [NUM_CORES-1:0]  fifo_empty;
  logic [NUM_CORES-1:0]  fifo_full;
  logic [NUM_CORES-1:0]  push;
  logic [NUM_CORES-1:0]  pop;
  entry_t                head [NUM_CORES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

  always_comb begin
    qual = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      case (filter_mode)
        2'd0:    qual[k] = 1'b1;
        2'd1:    qual[k] = trace_jal[k] | trace_jalr[k];
        2'd2:    qual[k] = trace_jalr[k];
        default: qual[k] = 1'b0;
      endcase
      qual[k] = qual[k] & enable & trace_valid[k];
    end
  end

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    entry_t           mem [FIFO_DEPTH];
    entry_t           wr_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [7:0]       lost_cnt;

    // Full comes from registered occupancy, so a same-cycle pop never frees room.
    assign fifo_empty[k] = (count == '0);
    assign fifo_full[k]  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign push[k]       = qual[k] & ~fifo_full[k];
    assign head[k]       = mem[rd_ptr];

    assign wr_entry = '{
      pc:   trace_pc[k*ADDR_WIDTH +: ADDR_WIDTH],
      npc:  trace_npc[k*ADDR_WIDTH +: ADDR_WIDTH],
      kind: {trace_jalr[k], trace_jal[k]},
      ts:   ts_cnt,
      lost: lost_cnt
    };

    always_ff @(posedge clk) begin
      if (push[k]) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        lost_cnt <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[k])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        // A qualifying event that was not pushed was dropped on a full FIFO.
        if (push[k])                         lost_cnt <= '0;
        else if (qual[k] && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 1'b1;
      end
    end
  end

  assign out_load = !ev.ev_valid || ev.ev_ready;

  // First non-empty FIFO at or after rr_ptr, wrapping at NUM_CORES.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_idx = {1'b0, rr_ptr} + (CID_W+1)'(i);
      if (scan_idx >= (CID_W+1)'(NUM_CORES)) scan_idx = scan_idx - (CID_W+1)'(NUM_CORES);
      if (!gnt_found && !fifo_empty[scan_idx[CID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx[CID_W-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (out_load && gnt_found) pop[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev.ev_valid   <= 1'b0;
      ev.ev_core_id <= '0;
      ev.ev_pc      <= '0;
      ev.ev_npc     <= '0;
      ev.ev_kind    <= '0;
      ev.ev_time    <= '0;
      ev.ev_lost    <= '0;
      rr_ptr        <= '0;
    end else if (out_load) begin
      ev.ev_valid <= gnt_found;
      if (gnt_found) begin
        ev.ev_core_id <= gnt_id;
        ev.ev_pc      <= head[gnt_id].pc;
        ev.ev_npc     <= head[gnt_id].npc;
        ev.ev_kind    <= head[gnt_id].kind;
        ev.ev_time    <= head[gnt_id].ts;
        ev.ev_lost    <= head[gnt_id].lost;
        rr_ptr        <= (gnt_id == CID_W'(NUM_CORES-1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_peripheral_dbg_soc_ctm_trace_mux.sv
// Bench for the CTM trace mux: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_peripheral_dbg_soc_ctm_trace_mux;
  localparam int NC    = 4;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int TW    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        filter_mode = 2'd0;
  logic [NC-1:0]     trace_valid = '0;
  logic [NC-1:0]     trace_jal = '0;
  logic [NC-1:0]     trace_jalr = '0;
  logic [AW-1:0]     pc_a [NC];
  logic [AW-1:0]     npc_a [NC];
  logic [NC*AW-1:0]  trace_pc;
  logic [NC*AW-1:0]  trace_npc;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NC; k++) begin : g_pack
    assign trace_pc[k*AW +: AW]  = pc_a[k];
    assign trace_npc[k*AW +: AW] = npc_a[k];
  end

  peripheral_dbg_soc_ctm_trace_mux_if #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .TIME_WIDTH(TW)) ev_if ();

  peripheral_dbg_soc_ctm_trace_mux #(
    .NUM_CORES(NC), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIME_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .filter_mode(filter_mode),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_npc(trace_npc),
    .trace_jal(trace_jal), .trace_jalr(trace_jalr), .ev(ev_if)
  );

  typedef struct packed {
    logic [1:0]    id;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic [1:0]    kind;
    logic [TW-1:0] ts;
    logic [7:0]    lost;
  } ev_t;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  vld, jal, jalr;
    logic [31:0] base;
    logic        ev;
    logic [1:0]  id, kind;
    logic [7:0]  ts;
    logic [31:0] pc;
  } vec_t;

  // reference model state
  ev_t mq [NC][$];
  int  mlost [NC];
  int  mrr;
  bit  mv;
  ev_t mout;

  int cyc;
  int total = 0;
  int bad = 0;
  vec_t vecs [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic ev_t act_ev();
    return '{id: ev_if.ev_core_id, pc: ev_if.ev_pc, npc: ev_if.ev_npc,
             kind: ev_if.ev_kind, ts: ev_if.ev_time, lost: ev_if.ev_lost};
  endfunction

  function automatic bit qualifies(int k);
    if (!enable || !trace_valid[k]) return 1'b0;
    case (filter_mode)
      2'd0:    return 1'b1;
      2'd1:    return trace_jal[k] || trace_jalr[k];
      2'd2:    return trace_jalr[k];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      mq[k].delete();
      mlost[k] = 0;
    end
    mrr = 0;
    mv  = 1'b0;
    cyc = 0;
  endtask

  // One clock of the spec's behaviour, evaluated from the inputs of the current cycle.
  task automatic model_update();
    bit  load;
    int  g;
    int  sz [NC];
    ev_t e;
    load = !mv || ev_if.ev_ready;
    for (int k = 0; k < NC; k++) sz[k] = mq[k].size();
    g = -1;
    for (int i = 0; i < NC; i++) begin
      int k;
      k = (mrr + i) % NC;
      if (g < 0 && sz[k] > 0) g = k;
    end
    for (int k = 0; k < NC; k++) begin
      if (qualifies(k)) begin
        if (sz[k] < DEPTH) begin
          e.id = 2'(k); e.pc = pc_a[k]; e.npc = npc_a[k];
          e.kind = {trace_jalr[k], trace_jal[k]};
          e.ts = TW'(cyc); e.lost = 8'(mlost[k]);
          mq[k].push_back(e);
          mlost[k] = 0;
        end else if (mlost[k] < 255) begin
          mlost[k]++;
        end
      end
    end
    if (load) begin
      if (g >= 0) begin
        mout = mq[g].pop_front();
        mv   = 1'b1;
        mrr  = (g + 1) % NC;
      end else begin
        mv = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    chk("model_valid", 128'(ev_if.ev_valid), 128'(mv));
    if (mv) chk("model_event", 128'(act_ev()), 128'(mout));
  endtask

  task automatic set_idle();
    trace_valid = '0;
    trace_jal   = '0;
    trace_jalr  = '0;
  endtask

  task automatic set_pcs(input logic [31:0] base);
    for (int k = 0; k < NC; k++) begin
      pc_a[k]  = base + 32'(k * 16);
      npc_a[k] = base + 32'h100 + 32'(k * 16);
    end
  endtask

  function automatic vec_t mk(logic en, logic [1:0] mode, logic [3:0] vld, logic [3:0] jal,
                              logic [3:0] jalr, logic [31:0] base, logic ev, logic [1:0] id,
                              logic [1:0] kind, logic [7:0] ts, logic [31:0] pc);
    vec_t v;
    v.en = en; v.mode = mode; v.vld = vld; v.jal = jal; v.jalr = jalr; v.base = base;
    v.ev = ev; v.id = id; v.kind = kind; v.ts = ts; v.pc = pc;
    return v;
  endfunction

  function automatic vec_t idle_exp(logic ev, logic [1:0] id, logic [1:0] kind,
                                    logic [7:0] ts, logic [31:0] pc);
    return mk(1'b1, 2'd0, 4'b0, 4'b0, 4'b0, 32'h0, ev, id, kind, ts, pc);
  endfunction

  logic [TW-1:0] hold_ts;
  int            cap;

  initial begin
    // directed table: one row per cycle, cycle 0 is the first cycle after reset release
    for (int i = 0; i < 5; i++) vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'b0001, 4'b0001, 4'b0000, 32'h100, 0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(1, 0, 2'b01, 8'd5, 32'h100));
    vecs.push_back(mk(1, 0, 4'b1000, 4'b0000, 4'b0000, 32'h500, 0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(1, 3, 2'b00, 8'd8, 32'h530));
    vecs.push_back(mk(1, 0, 4'b1111, 4'b0101, 4'b1010, 32'h600, 0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(1, 0, 2'b01, 8'd11, 32'h600));
    vecs.push_back(idle_exp(1, 1, 2'b10, 8'd11, 32'h610));
    vecs.push_back(idle_exp(1, 2, 2'b01, 8'd11, 32'h620));
    vecs.push_back(idle_exp(1, 3, 2'b10, 8'd11, 32'h630));
    vecs.push_back(mk(1, 0, 4'b1010, 4'b1010, 4'b0000, 32'h700, 0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(1, 1, 2'b01, 8'd17, 32'h710));
    vecs.push_back(idle_exp(1, 3, 2'b01, 8'd17, 32'h730));
    vecs.push_back(mk(1, 0, 4'b1001, 4'b0000, 4'b0000, 32'h780, 0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(1, 0, 2'b00, 8'd21, 32'h780));
    vecs.push_back(idle_exp(1, 3, 2'b00, 8'd21, 32'h7b0));
    vecs.push_back(mk(1, 2, 4'b0010, 4'b0010, 4'b0000, 32'h800, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 4'b0010, 4'b0000, 4'b0010, 32'h900, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 4'b0010, 4'b0000, 4'b0000, 32'ha00, 0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(1, 1, 2'b10, 8'd26, 32'h910));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0001, 4'b0010, 32'hb00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 4'b1111, 4'b1111, 4'b0000, 32'hc00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0000, 32'hd00, 1, 0, 2'b01, 8'd31, 32'hb00));
    vecs.push_back(idle_exp(1, 1, 2'b10, 8'd31, 32'hb10));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));
    vecs.push_back(idle_exp(0, 0, 0, 0, 0));

    // clock/reset
    set_idle();
    set_pcs(32'h0);
    ev_if.ev_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 128'(ev_if.ev_valid), 128'(0));
    chk("reset_data", 128'(act_ev()), 128'(0));
    rst_n = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      enable = vecs[i].en; filter_mode = vecs[i].mode;
      trace_valid = vecs[i].vld; trace_jal = vecs[i].jal; trace_jalr = vecs[i].jalr;
      set_pcs(vecs[i].base);
      ev_if.ev_ready = 1'b1;
      chk($sformatf("vec%0d_valid", i), 128'(ev_if.ev_valid), 128'(vecs[i].ev));
      if (vecs[i].ev)
        chk($sformatf("vec%0d_event", i),
            128'({ev_if.ev_core_id, ev_if.ev_kind, ev_if.ev_time, ev_if.ev_pc, ev_if.ev_npc, ev_if.ev_lost}),
            128'({vecs[i].id, vecs[i].kind, vecs[i].ts, vecs[i].pc, vecs[i].pc + 32'h100, 8'h0}));
      tick();
    end

    // stall: output holds a core-0 event while core 2 fills, then drops 3
    enable = 1'b1; filter_mode = 2'd0; ev_if.ev_ready = 1'b0;
    set_idle(); trace_valid = 4'b0001; trace_jal = 4'b0001; set_pcs(32'h1000);
    tick();
    set_idle();
    tick();
    hold_ts = TW'(cyc - 2);
    for (int i = 0; i < 7; i++) begin
      trace_valid = 4'b0100; trace_jal = 4'b0100; set_pcs(32'h2000 + 32'(i * 256));
      ev_if.ev_ready = (i == 6);
      chk("stall_hold", 128'({ev_if.ev_valid, ev_if.ev_core_id, ev_if.ev_time, ev_if.ev_pc}),
          128'({1'b1, 2'd0, hold_ts, 32'h1000}));
      tick();
    end
    set_idle(); ev_if.ev_ready = 1'b1;
    repeat (6) tick();
    cap = cyc;
    trace_valid = 4'b0100; trace_jalr = 4'b0100; set_pcs(32'h3000);
    tick();
    set_idle();
    tick();
    chk("lost_three", 128'({ev_if.ev_valid, ev_if.ev_core_id, ev_if.ev_lost, ev_if.ev_time}),
        128'({1'b1, 2'd2, 8'd3, TW'(cap)}));

    // saturation: hundreds of drops on core 0 report as 255, then the count restarts
    ev_if.ev_ready = 1'b0;
    trace_valid = 4'b0001; trace_jal = 4'b0001; set_pcs(32'h4000);
    repeat (310) tick();
    set_idle(); ev_if.ev_ready = 1'b1;
    repeat (8) tick();
    cap = cyc;
    trace_valid = 4'b0001; trace_jal = 4'b0001; set_pcs(32'h5000);
    tick();
    set_pcs(32'h6000);
    tick();
    set_idle();
    chk("lost_sat", 128'({ev_if.ev_valid, ev_if.ev_core_id, ev_if.ev_lost, ev_if.ev_time}),
        128'({1'b1, 2'd0, 8'd255, TW'(cap)}));
    tick();
    chk("lost_clear", 128'({ev_if.ev_valid, ev_if.ev_core_id, ev_if.ev_lost, ev_if.ev_time}),
        128'({1'b1, 2'd0, 8'd0, TW'(cap + 1)}));
    repeat (3) tick();

    // randomized traffic with alternating light and heavy backpressure
    for (int i = 0; i < 800; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      filter_mode = 2'($urandom_range(0, 3));
      trace_valid = NC'($urandom);
      trace_jal   = NC'($urandom);
      trace_jalr  = NC'($urandom);
      for (int k = 0; k < NC; k++) begin
        pc_a[k]  = $urandom;
        npc_a[k] = $urandom;
      end
      ev_if.ev_ready = ($urandom_range(0, 9) < (((i / 100) % 2 == 1) ? 2 : 8));
      tick();
    end

    // asynchronous reset with buffered events
    set_idle(); enable = 1'b1; filter_mode = 2'd0; ev_if.ev_ready = 1'b0;
    trace_valid = 4'b1111; set_pcs(32'h7000);
    repeat (3) tick();
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(ev_if.ev_valid), 128'(0));
    chk("async_data", 128'(act_ev()), 128'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ev_if.ev_ready = 1'b1;
    chk("post_reset_valid", 128'(ev_if.ev_valid), 128'(0));
    repeat (2) tick();
    cap = cyc;
    trace_valid = 4'b0010; trace_jalr = 4'b0010; set_pcs(32'h8000);
    tick();
    set_idle();
    tick();
    chk("post_reset_ts", 128'({ev_if.ev_valid, ev_if.ev_core_id, ev_if.ev_kind, ev_if.ev_time}),
        128'({1'b1, 2'd1, 2'b10, 8'd2}));
    chk("post_reset_cap", 128'(cap), 128'(2));
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/peripheral_dbg_soc_ctm_trace_mux.md
# peripheral_dbg_soc_ctm_trace_mux

Multi-core successor to the single-core MRISCV core-trace adapter. It samples `NUM_CORES` execution-trace ports and applies a per-block filter mode. Each qualifying event is timestamped and buffered in a per-core FIFO. Lost events are counted per core, and a round-robin arbiter merges all cores into one registered valid/ready event stream that feeds the CTM packetiser.

## Interface
Parameters:
- `NUM_CORES`, 4: number of trace ports; ≥1.
- `ADDR_WIDTH`, 32: PC width.
- `FIFO_DEPTH`, 4: entries per core FIFO; power of 2, ≥2.
- `TIME_WIDTH`, 32: timestamp counter width.
- `CID_W` (localparam): `NUM_CORES>1 ? $clog2(NUM_CORES) : 1`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable.
- `filter_mode`  in  2  0=every valid retire, 1=jal|jalr only, 2=jalr only, 3=capture nothing.
- `trace_valid`  in  NUM_CORES  per-core retire strobe.
- `trace_pc`  in  NUM_CORES*ADDR_WIDTH  core k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `trace_npc`  in  NUM_CORES*ADDR_WIDTH  jump/branch target, same packing.
- `trace_jal`, `trace_jalr`  in  NUM_CORES each  instruction-kind flags.
- `ev_valid`  out  1  output event present.
- `ev_ready`  in  1  consumer accepts.
- `ev_core_id`  out  CID_W  source core.
- `ev_pc`, `ev_npc`  out  ADDR_WIDTH each.
- `ev_kind`  out  2  {jalr, jal}.
- `ev_time`  out  TIME_WIDTH  timestamp at capture.
- `ev_lost`  out  8  events from this core dropped before this one.

## Operation
- Timestamp counter: 0 in the first cycle after reset release; +1 every cycle; wraps modulo 2^TIME_WIDTH. It is independent of `enable`.
- Qualify (per core, per cycle): `enable && trace_valid[k] && mode_ok`.
  - mode_ok is: mode 0 → 1; mode 1 → jal|jalr; mode 2 → jalr; mode 3 → 0.
- Capture: a qualifying event is pushed as {pc, npc, {jalr,jal}, time, lost_cnt[k]}.
  - On push, `lost_cnt[k]` clears to 0.
- Full: `full` is taken from the registered occupancy. A qualifying event while full is dropped, even if a pop of the same FIFO occurs that cycle.
  - On drop, `lost_cnt[k]` increments and saturates at 255.
  - The count is reported with the next pushed event.
- Arbiter: the output register loads when `!ev_valid || ev_ready`.
  - It grants the first non-empty FIFO searching from `rr_ptr` upward, with wrap.
  - That FIFO is popped and its entry loaded, with `ev_core_id`=k.
  - `rr_ptr` then becomes (k+1) mod NUM_CORES.
  - If every FIFO is empty, `ev_valid`→0 and `rr_ptr` is unchanged.
- Valid/ready: while `ev_valid && !ev_ready`, all `ev_*` outputs hold stable. Back-to-back transfers at 1 event/cycle are supported.
- Deasserting `enable` stops new captures only. Buffered entries still drain, and `lost_cnt` is retained.
- `filter_mode`/`enable` changes take effect on the same-cycle qualification. There is no pipeline of configuration.
- Reset, asynchronous including mid-operation, clears:
  - all FIFOs (discarding contents), `lost_cnt`, `rr_ptr`=0, timestamp=0;
  - `ev_valid`=0 and all `ev_*` data outputs = 0.

## Timing
- Latency: an event qualifying in cycle t is written at the end of t.
  - Its FIFO is non-empty in t+1. With the output free and the core granted, it is popped at the end of t+1.
  - `ev_valid` rises in t+2 with `ev_time` = counter value in t.
- Throughput: each core sustains 1 capture/cycle. The output sustains 1 event/cycle total, so an aggregate rate above 1/cycle fills FIFOs.
- Simultaneous events on all cores in one cycle: each goes to its own FIFO. They emerge in rr order starting at `rr_ptr`, consecutive cycles if `ev_ready`=1.
- FIFO push and pop of the same FIFO in one cycle (not full): both occur, occupancy unchanged.
- Timestamp wrap: the all-ones value is followed by 0. There is no flag; the consumer handles wrap.

## Test plan
- Reset, then core 0 valid with jal=1, pc=0x100, npc=0x200, mode 0, in cycle 5 → `ev_valid` in cycle 7, `ev_core_id`=0, `ev_kind`=01, `ev_time`=5, `ev_lost`=0.
- Mode 2, core 1 valid in cycle 3 (jal), cycle 4 (jalr), cycle 5 (neither) → exactly one event: kind 10, time=4.
- All 4 cores valid in the same cycle, `ev_ready`=1 → core ids 0,1,2,3 in consecutive cycles. Then a second burst from cores 1 and 3 gives order 1,3, then `rr_ptr`=0.
- `ev_ready`=0, core 2 valid on 7 consecutive cycles, FIFO_DEPTH=4 → 4 stored (the 5th write is dropped even if the output takes one), 3 dropped. After draining, a new event carries `ev_lost`=3. Outputs are stable throughout the stall.
- 300 drops on core 0 → next event `ev_lost`=255. The following event has `ev_lost`=0.
- Assert `rst_n`=0 while `ev_valid`=1 and FIFOs are non-empty → `ev_valid`=0 immediately (asynchronous). After release, no stale event appears and the timestamp restarts at 0.
